// File: rtl/sc_speedcounter.sv
// Speed counter for the game timing path. It counts cycles while running and
// emits a one-cycle tick when the external comparator reports that the count
// has reached the threshold for the current speed level.
module sc_speedcounter #(
    parameter int SPEEDCOUNTER_DATAWIDTH = 23
) (
    input  logic                              SC_SPEEDCOUNTER_CLOCK_50,
    input  logic                              SC_SPEEDCOUNTER_RESET_InHigh,
    input  logic                              SC_SPEEDCOUNTER_run_InHigh,
    input  logic                              SC_SPEEDCOUNTER_clear_InHigh,
    input  logic                              SC_SPEEDCOUNTER_levelUp_InHigh,
    input  logic                              SC_SPEEDCOUNTER_T0_InLow,
    output logic [SPEEDCOUNTER_DATAWIDTH-1:0] SC_SPEEDCOUNTER_data_OutBUS,
    output logic [1:0]                        SC_SPEEDCOUNTER_nivel_OutBUS,
    output logic                              SC_SPEEDCOUNTER_tick_OutHigh,
    output logic [1:0]                        SC_SPEEDCOUNTER_state_OutBUS
);

    localparam int W = SPEEDCOUNTER_DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        TICK  = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] count, count_n;
    logic [1:0]   level, level_n;

    // State, count and level registers; reset outranks every other input.
    always_ff @(posedge SC_SPEEDCOUNTER_CLOCK_50) begin
        if (SC_SPEEDCOUNTER_RESET_InHigh) begin
            state <= IDLE;
            count <= '0;
            level <= 2'b00;
        end else begin
            state <= state_n;
            count <= count_n;
            level <= level_n;
        end
    end

    // Next-state decode: base FSM first, then levelUp, then clear as overrides.
    always_comb begin
        state_n = state;
        count_n = count;
        level_n = level;

        case (state)
            IDLE: begin
                count_n = '0;
                if (SC_SPEEDCOUNTER_run_InHigh)
                    state_n = COUNT;
            end
            COUNT: begin
                if (!SC_SPEEDCOUNTER_run_InHigh) begin
                    state_n = HOLD;
                end else if (!SC_SPEEDCOUNTER_T0_InLow) begin
                    state_n = TICK;
                    count_n = '0;
                end else begin
                    // Free-running wrap; only the comparator can raise a tick.
                    count_n = count + W'(1);
                end
            end
            TICK: begin
                // Comparator result is stale here (count was just cleared).
                if (SC_SPEEDCOUNTER_run_InHigh) begin
                    state_n = COUNT;
                    count_n = count + W'(1);
                end else begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // A tick pending at pause time fires on the first COUNT cycle.
                if (SC_SPEEDCOUNTER_run_InHigh)
                    state_n = COUNT;
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase

        // Level advance restarts the count even when already saturated.
        if (SC_SPEEDCOUNTER_levelUp_InHigh) begin
            level_n = (level == 2'b11) ? 2'b11 : level + 2'd1;
            count_n = '0;
        end

        if (SC_SPEEDCOUNTER_clear_InHigh) begin
            state_n = IDLE;
            count_n = '0;
            level_n = 2'b00;
        end
    end

    assign SC_SPEEDCOUNTER_data_OutBUS  = count;
    assign SC_SPEEDCOUNTER_nivel_OutBUS = level;
    assign SC_SPEEDCOUNTER_state_OutBUS = state;
    assign SC_SPEEDCOUNTER_tick_OutHigh = (state == TICK);

endmodule
